mod_counter: RTL and testbench

//   Parametrised modulo counter; successor to the fixed 4-bit free-running counter.

---
 rtl/mod_counter.sv | 135 +++++++++++++
 tb/tb_mod_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Parametrised modulo counter: up/down, clear/load, enable, terminal-count strobe, one-shot.
// Optional step prescaler enabled by defining MOD_COUNTER_PRESCALE_EN.
module mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULO   = 16,
    parameter int unsigned ONESHOT  = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    if ((WIDTH < 1) || (MODULO < 2) || (((MODULO - 1) >> WIDTH) != 0) || (PRESCALE < 1)) begin : g_param_check
        $error("mod_counter: illegal parameter combination");
    end

    localparam int unsigned    MOD_I = MODULO;
    localparam logic [WIDTH:0] MOD_X = MOD_I[WIDTH:0];
    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] TOP_X = MOD_X - ONE_X;

    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   count_x_s;
    logic [WIDTH:0]   term_x_s;
    logic [WIDTH:0]   next_x_s;
    logic [WIDTH:0]   load_x_s;
    logic [WIDTH-1:0] load_clamp_s;
    logic             at_term_s;
    logic             tick_s;
    logic             step_s;

    // Arithmetic is carried one bit wider so MODULO = 2**WIDTH compares correctly.
    assign count_x_s    = {1'b0, count_q};
    assign term_x_s     = up ? TOP_X : {(WIDTH+1){1'b0}};
    assign at_term_s    = (count_x_s == term_x_s);
    assign next_x_s     = up ? (count_x_s + ONE_X) : (count_x_s - ONE_X);
    assign load_x_s     = {1'b0, load_val};
    assign load_clamp_s = (load_x_s >= MOD_X) ? TOP_X[WIDTH-1:0] : load_val;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int unsigned    PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned    PRE_TOP_I = PRESCALE - 1;
    localparam logic [PW-1:0]  PRE_TOP   = PRE_TOP_I[PW-1:0];
    localparam logic [PW-1:0]  PRE_ONE   = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] pre_q, pre_d;

    assign tick_s = en & (pre_q == PRE_TOP);

    // Prescaler advances on every enabled cycle and wraps on tick.
    always_comb begin
        pre_d = pre_q;
        if (clr || load) begin
            pre_d = {PW{1'b0}};
        end else if (en) begin
            if (pre_q == PRE_TOP) begin
                pre_d = {PW{1'b0}};
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end else begin
            pre_d = pre_q;
        end
    end

    // Prescaler state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= {PW{1'b0}};
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    assign step_s = en & tick_s & ~done_q;

    // Next state: clear beats load beats step.
    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_clamp_s;
            done_d  = 1'b0;
        end else if (step_s) begin
            if (at_term_s) begin
                if (ONESHOT != 0) begin
                    count_d = count_q;
                    done_d  = 1'b1;
                end else begin
                    count_d = up ? {WIDTH{1'b0}} : TOP_X[WIDTH-1:0];
                    done_d  = 1'b0;
                end
            end else begin
                count_d = (next_x_s >= MOD_X) ? TOP_X[WIDTH-1:0] : next_x_s[WIDTH-1:0];
                done_d  = done_q;
            end
        end else begin
            count_d = count_q;
            done_d  = done_q;
        end
    end

    // Count and one-shot state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= {WIDTH{1'b0}};
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Strobe is forced low during reset so a cascaded stage never sees a spurious enable.
    assign tc    = rst & step_s & at_term_s & ~clr & ~load;
    assign count = count_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter: wrap/down counting, load clamp, priority,
// one-shot, async reset and (when MOD_COUNTER_PRESCALE_EN is defined) prescaled stepping.
module tb_mod_counter;

    logic clk = 1'b0;
    logic rst;

    logic       clr_a, load_a, en_a, up_a;
    logic [3:0] load_val_a, count_a;
    logic       tc_a, done_a;

    logic       clr_b, load_b, en_b, up_b;
    logic [2:0] load_val_b, count_b;
    logic       tc_b, done_b;

    logic       clr_c, load_c, en_c, up_c;
    logic [3:0] load_val_c, count_c;
    logic       tc_c, done_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULO(10), .ONESHOT(0), .PRESCALE(1)) u_dut_a (
        .clk(clk), .rst(rst), .clr(clr_a), .load(load_a), .load_val(load_val_a),
        .en(en_a), .up(up_a), .count(count_a), .tc(tc_a), .done(done_a));

    mod_counter #(.WIDTH(3), .MODULO(4), .ONESHOT(1), .PRESCALE(1)) u_dut_b (
        .clk(clk), .rst(rst), .clr(clr_b), .load(load_b), .load_val(load_val_b),
        .en(en_b), .up(up_b), .count(count_b), .tc(tc_b), .done(done_b));

    mod_counter #(.WIDTH(4), .MODULO(10), .ONESHOT(0), .PRESCALE(3)) u_dut_c (
        .clk(clk), .rst(rst), .clr(clr_c), .load(load_c), .load_val(load_val_c),
        .en(en_c), .up(up_c), .count(count_c), .tc(tc_c), .done(done_c));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_c[11];
        logic en_pat[11];
        en_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef MOD_COUNTER_PRESCALE_EN
        exp_c = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
`else
        exp_c = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 8, 9};
`endif

        rst = 1'b0;
        {clr_a, load_a, up_a} = 3'b000; en_a = 1'b1; load_val_a = 4'd0;
        {clr_b, load_b, en_b, up_b} = 4'b0000; load_val_b = 3'd0;
        {clr_c, load_c, en_c} = 3'b000; up_c = 1'b1; load_val_c = 4'd0;

        // Reset state; up=0 at count 0 would be terminal, so tc must be held low by rst.
        #50;
        check_eq("rst_count_a", 32'(count_a), 32'd0);
        check_eq("rst_tc_a", 32'(tc_a), 32'd0);
        check_eq("rst_done_b", 32'(done_b), 32'd0);
        up_a = 1'b1;
        #52;
        rst = 1'b1;
        #1;
        check_eq("rel_count_a", 32'(count_a), 32'd0);
        check_eq("rel_tc_a", 32'(tc_a), 32'd0);

        // Up count with wrap.
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq($sformatf("up_count_%0d", i), 32'(count_a), 32'(i % 10));
            check_eq($sformatf("up_tc_%0d", i), 32'(tc_a), ((i % 10) == 9) ? 32'd1 : 32'd0);
        end

        // Down count from 0: terminal follows up immediately.
        up_a = 1'b0;
        #1;
        check_eq("dn_tc_at0", 32'(tc_a), 32'd1);
        for (int j = 1; j <= 3; j++) begin
            tick();
            check_eq($sformatf("dn_count_%0d", j), 32'(count_a), 32'(10 - j));
            check_eq($sformatf("dn_tc_%0d", j), 32'(tc_a), 32'd0);
        end

        // Load clamp, clear-over-load priority, tc gated by load.
        load_a = 1'b1; load_val_a = 4'd13;
        #1;
        check_eq("ld_tc", 32'(tc_a), 32'd0);
        tick();
        check_eq("ld_clamp13", 32'(count_a), 32'd9);
        clr_a = 1'b1; load_val_a = 4'd5;
        tick();
        check_eq("clr_over_ld", 32'(count_a), 32'd0);
        clr_a = 1'b0;
        #1;
        check_eq("ld_tc_at_term", 32'(tc_a), 32'd0);
        load_val_a = 4'd10;
        tick();
        check_eq("ld_clamp10", 32'(count_a), 32'd9);
        load_val_a = 4'd5;
        tick();
        check_eq("ld_5", 32'(count_a), 32'd5);
        load_a = 1'b0; en_a = 1'b0;
        tick();
        check_eq("hold_en0", 32'(count_a), 32'd5);

        // One-shot.
        en_b = 1'b1; up_b = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("os_count_%0d", k), 32'(count_b), 32'(k));
            check_eq($sformatf("os_done_%0d", k), 32'(done_b), 32'd0);
        end
        check_eq("os_tc_term", 32'(tc_b), 32'd1);
        tick();
        check_eq("os_hold", 32'(count_b), 32'd3);
        check_eq("os_done", 32'(done_b), 32'd1);
        check_eq("os_tc_done", 32'(tc_b), 32'd0);
        tick();
        check_eq("os_hold2", 32'(count_b), 32'd3);
        check_eq("os_done2", 32'(done_b), 32'd1);
        load_b = 1'b1; load_val_b = 3'd1;
        tick();
        check_eq("os_reload", 32'(count_b), 32'd1);
        check_eq("os_reload_done", 32'(done_b), 32'd0);
        load_b = 1'b0;
        tick(); tick(); tick();
        check_eq("os_again_count", 32'(count_b), 32'd3);
        check_eq("os_again_done", 32'(done_b), 32'd1);

        // Mid-count async reset.
        en_a = 1'b1; up_a = 1'b1;
        tick();
        check_eq("pre_rst_count_a", 32'(count_a), 32'd6);
        #3;
        up_a = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("arst_count_a", 32'(count_a), 32'd0);
        check_eq("arst_tc_a", 32'(tc_a), 32'd0);
        check_eq("arst_count_b", 32'(count_b), 32'd0);
        check_eq("arst_done_b", 32'(done_b), 32'd0);
        #17;
        check_eq("arst_hold_a", 32'(count_a), 32'd0);
        rst = 1'b1;
        tick();
        check_eq("resume_a", 32'(count_a), 32'd9);
        check_eq("resume_b", 32'(count_b), 32'd1);
        en_a = 1'b0; en_b = 1'b0;

        // Prescaled counter (steps every cycle in the default build).
        for (int m = 0; m < 11; m++) begin
            en_c = en_pat[m];
            tick();
            check_eq($sformatf("pre_count_%0d", m), 32'(count_c), 32'(exp_c[m]));
        end
        check_eq("pre_done_c", 32'(done_c), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
